// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NIBBLE_W = 4;

  // Column index to active-low one-cold drive pattern.
  function automatic logic [NUM_COLS-1:0] col_decode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; 2-cycle latency, no flow control.
module sync_2ff #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce and 32-bit key history; commit visible one edge after scan end.
// CPU reads are never stalled: rd clears the new-key flag, wr clears history and flag.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 8192,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [3:0]  i_row,
  output logic [3:0]  o_col,
  output logic [31:0] o_data,
  output logic        o_valid
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]    div_cnt;
  logic [1:0]          col_idx;
  logic [NUM_ROWS-1:0] row_sync;
  logic [NUM_ROWS-1:0] row_hit;
  logic                slot_end;
  logic                scan_end;
  logic [2:0]          slot_hits;
  logic [1:0]          slot_row;
  logic [4:0]          hits_acc;
  logic [4:0]          hits;
  logic [NIBBLE_W-1:0] code_acc;
  logic [NIBBLE_W-1:0] code;
  logic                single;
  state_t              state, state_n;
  logic [NIBBLE_W-1:0] cand, cand_n;
  logic [3:0]          cnt, cnt_n;
  logic                commit;
  logic                rd_clr;
  logic                wr_clr;

  // Idle rows read high, so the synchronizer resets to "nothing pressed".
  sync_2ff #(.WIDTH(NUM_ROWS), .RESET_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_row),
    .q     (row_sync)
  );

  assign row_hit  = ~row_sync;
  assign slot_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_end = slot_end && (col_idx == 2'd3);

  always_comb begin
    slot_hits = '0;
    slot_row  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_hit[r]) begin
        slot_hits = slot_hits + 3'd1;
        slot_row  = 2'(r);
      end
    end
  end

  // Totals include the slot being closed, so scan_end sees the whole scan.
  assign hits   = hits_acc + {2'b00, slot_hits};
  assign code   = (slot_hits != 3'd0) ? {slot_row, col_idx} : code_acc;
  assign single = (hits == 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      col_idx  <= 2'd0;
      o_col    <= col_decode(2'd0);
      hits_acc <= '0;
      code_acc <= '0;
    end else if (slot_end) begin
      div_cnt  <= '0;
      col_idx  <= col_idx + 2'd1;
      o_col    <= col_decode(col_idx + 2'd1);
      hits_acc <= scan_end ? 5'd0 : hits;
      code_acc <= scan_end ? 4'd0 : code;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    commit  = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_n = code;
            cnt_n  = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              commit  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (single && (code == cand)) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n == 4'(DEBOUNCE_SCANS)) begin
              commit  = 1'b1;
              state_n = HELD;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (hits == 5'd0) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rd_clr = cs && i_rd;
  assign wr_clr = cs && i_wr;

  // A commit always wins the flag; a same-cycle write only drops older history.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (commit) begin
      o_data  <= {(wr_clr ? 28'h0 : o_data[27:0]), code};
      o_valid <= 1'b1;
    end else if (wr_clr) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (rd_clr) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad matrix model and a history scoreboard.
module tb_keypad_scan;
  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        i_rd;
  logic        i_wr;
  logic [3:0]  i_row;
  logic [3:0]  o_col;
  logic [31:0] o_data;
  logic        o_valid;

  logic [15:0] keys;
  int          checks = 0;
  int          failures = 0;
  int          commits = 0;
  int          base;
  logic        prev_valid = 1'b0;
  logic [31:0] hist;
  logic [31:0] exp_q[$];
  logic [31:0] expv;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .i_rd    (i_rd),
    .i_wr    (i_wr),
    .i_row   (i_row),
    .o_col   (o_col),
    .o_data  (o_data),
    .o_valid (o_valid)
  );

  // Pressed key (r,c) pulls row r low only while column c is driven low.
  always_comb begin
    i_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (o_valid && !prev_valid) commits++;
    prev_valid <= o_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge right after column 0 becomes active.
  task automatic align_scan();
    int budget;
    budget = 64;
    while (o_col == 4'b1110 && budget > 0) begin tick(1); budget--; end
    while (o_col != 4'b1110 && budget > 0) begin tick(1); budget--; end
    if (budget == 0) begin
      checks++;
      failures++;
      $error("FAIL align_timeout observed=0x%0h expected=0xe", o_col);
    end
  endtask

  task automatic push_key(input logic [3:0] code);
    hist = {hist[27:0], code};
    exp_q.push_back(hist);
  endtask

  task automatic stroke(input logic [3:0] code, input int scans);
    align_scan();
    keys = 16'd1 << code;
    tick(scans * SCAN);
    keys = '0;
    tick(SCAN);
  endtask

  task automatic strobe(input logic rd, input logic wr);
    cs = 1'b1; i_rd = rd; i_wr = wr;
    tick(1);
    cs = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cs = 1'b0; i_rd = 1'b0; i_wr = 1'b0; keys = '0; hist = '0;
    tick(3);
    reset = 1'b0;

    // Column walk after reset, each column held for one slot.
    for (int i = 0; i < 20; i++) begin
      expv = {28'h0, ~(4'b0001 << ((i / 4) % 4))};
      chk("col_walk", {28'h0, o_col}, expv);
      chk("rst_data", o_data, 32'h0);
      chk("rst_valid", {31'h0, o_valid}, 32'h0);
      tick(1);
    end

    // Key row1/col2 = 0x6.
    base = commits;
    push_key(4'h6);
    stroke(4'h6, 3);
    chk("key6_data", o_data, exp_q.pop_front());
    chk("key6_valid", {31'h0, o_valid}, 32'h1);

    strobe(1'b1, 1'b0);
    chk("rd_valid", {31'h0, o_valid}, 32'h0);
    chk("rd_data", o_data, 32'h6);

    // Key row2/col2 = 0xA with exact commit timing.
    push_key(4'hA);
    align_scan();
    keys = 16'd1 << 10;
    tick(31);
    chk("keyA_early", {31'h0, o_valid}, 32'h0);
    tick(1);
    chk("keyA_commit", {31'h0, o_valid}, 32'h1);
    tick(SCAN);
    keys = '0;
    tick(SCAN);
    chk("keyA_data", o_data, exp_q.pop_front());
    chk("two_commits", commits - base, 2);

    // One-scan press must not commit.
    strobe(1'b1, 1'b0);
    base = commits;
    align_scan();
    keys = 16'd1 << 6;
    tick(SCAN);
    keys = '0;
    tick(2 * SCAN);
    chk("short_commits", commits - base, 0);
    chk("short_data", o_data, 32'h6A);

    // Two rows in one column: ghost, no commit.
    align_scan();
    keys = (16'd1 << 1) | (16'd1 << 13);
    tick(5 * SCAN);
    keys = '0;
    tick(2 * SCAN);
    chk("ghost_commits", commits - base, 0);
    chk("ghost_data", o_data, 32'h6A);

    // Long hold gives a single commit.
    push_key(4'h5);
    stroke(4'h5, 10);
    tick(SCAN);
    chk("hold_commits", commits - base, 1);
    chk("hold_data", o_data, exp_q.pop_front());

    strobe(1'b0, 1'b1);
    hist = '0;
    chk("wr_data", o_data, 32'h0);
    chk("wr_valid", {31'h0, o_valid}, 32'h0);

    // Read strobe in the commit cycle of key 0xF.
    push_key(4'hF);
    align_scan();
    keys = 16'd1 << 15;
    tick(31);
    strobe(1'b1, 1'b0);
    chk("rdcommit_valid", {31'h0, o_valid}, 32'h1);
    chk("rdcommit_nib", {28'h0, o_data[3:0]}, 32'hF);
    chk("rdcommit_data", o_data, exp_q.pop_front());
    keys = '0;
    tick(2 * SCAN);

    // Write strobe in the commit cycle of key 0xF.
    strobe(1'b1, 1'b0);
    hist = '0;
    push_key(4'hF);
    align_scan();
    keys = 16'd1 << 15;
    tick(31);
    strobe(1'b0, 1'b1);
    chk("wrcommit_valid", {31'h0, o_valid}, 32'h1);
    chk("wrcommit_data", o_data, exp_q.pop_front());
    keys = '0;
    tick(2 * SCAN);

    strobe(1'b1, 1'b1);
    hist = '0;
    chk("rdwr_data", o_data, 32'h0);
    chk("rdwr_valid", {31'h0, o_valid}, 32'h0);

    // Nine keys wrap the history.
    for (int k = 1; k <= 9; k++) begin
      push_key(4'(k));
      stroke(4'(k), 3);
      chk("hist_step", o_data, exp_q.pop_front());
    end
    chk("hist_wrap", o_data, 32'h23456789);

    // Reset during debounce discards partial progress.
    align_scan();
    keys = 16'd1 << 1;
    tick(20);
    reset = 1'b1;
    tick(1);
    chk("midrst_col", {28'h0, o_col}, 32'hE);
    chk("midrst_data", o_data, 32'h0);
    chk("midrst_valid", {31'h0, o_valid}, 32'h0);
    reset = 1'b0;
    tick(31);
    chk("postrst_early", {31'h0, o_valid}, 32'h0);
    tick(1);
    chk("postrst_valid", {31'h0, o_valid}, 32'h1);
    chk("postrst_data", o_data, 32'h1);
    keys = '0;
    tick(SCAN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Memory-mapped 4x4 matrix keypad scanner: the CPU-read input counterpart of the seven-segment display output peripheral. Drives one active-low column at a time at a divided scan rate, samples the active-low rows, debounces a single pressed key over several full scans, encodes it as a hex nibble, and shifts it into a 32-bit key-history register. The CPU reads the history and a new-key flag over the same `cs`-style bus used by the other I/O peripherals.

## Interface
Parameters:
- `SCAN_DIV`, 8192: clk cycles per column slot. Must be ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive full scans that must see the same single key before it is committed. Range 1..15.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: peripheral select.
- `i_rd` in 1: read strobe. Qualified by `cs`.
- `i_wr` in 1: write strobe. Qualified by `cs`.
- `i_row` in 4: keypad rows, active-low, asynchronous.
- `o_col` out 4: column drive, active-low, exactly one bit low.
- `o_data` out 32: key history. Newest key in [3:0]; older keys shift toward [31:28].
- `o_valid` out 1: a new key has been committed since the last clear.

## Operation
- Reset values: `o_col`=4'b1110, `o_data`=0, `o_valid`=0, divider=0, column index=0, state IDLE, candidate=0, stable count=0.
- Synchronize `i_row` through 2 flops. The sampled row vector is `~row_sync`.
- Divider:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 (slot end), latch the sampled rows for the current column, then advance the column index 0→1→2→3→0.
  - `o_col` = ~(1<<col_idx), registered.
- Scan end is the slot end of column 3. Over that scan, compute `hits` (count of pressed positions, 0..16) and `code` = row*4 + col of the pressed position.
- `single` = (hits==1). Two or more keys count as no key (ghost rejection).
- FSM, evaluated only at scan end:
  - IDLE: if `single`, set cand=code and cnt=1. If DEBOUNCE_SCANS==1, commit and go to HELD; otherwise go to DEBOUNCE.
  - DEBOUNCE: if `single` and code==cand, cnt++. When cnt reaches DEBOUNCE_SCANS, commit and go to HELD. On any other result, go to IDLE.
  - HELD: if hits==0, go to IDLE; otherwise stay. No auto-repeat.
- Commit: `o_data` <= {o_data[27:0], cand}; `o_valid` <= 1.
- Bus:
  - `cs&&i_rd` clears `o_valid`.
  - `cs&&i_wr` clears `o_data` and `o_valid`.
  - `o_data` is always driven; `cs` does not gate it.
- Simultaneous events:
  - Commit with rd-clear: `o_valid`=1.
  - Commit with wr-clear: `o_data`={28'h0, cand} and `o_valid`=1.
  - rd and wr together: wr behaviour.

## Timing
- Row input to usable sample: 2 cycles of sync latency, absorbed within a slot because SCAN_DIV ≥ 4.
- Scan period is 4·SCAN_DIV cycles.
- Commit occurs in the scan-end cycle of the DEBOUNCE_SCANS-th consecutive matching scan. `o_data` and `o_valid` update on the following edge.
- A press shorter than DEBOUNCE_SCANS full scans never commits.
- Reset mid-operation, in any state and at any divider value, restores all reset values on the next edge. Partial debounce is discarded.
- History wrap-around: the 9th key shifts the oldest nibble out of [31:28]. No overflow flag.

## Structure
- `keypad_pkg`:
  - State enum {IDLE, DEBOUNCE, HELD}.
  - Column count (4), row count (4), nibble width.
  - Column-decode function idx→active-low one-cold.
- Sub-module `sync_2ff` (parameterized width). Reused for any asynchronous input.
- Scan accumulation (hits, code) lives in the top module, reset at each scan end.

## Test plan
Test bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2, scan = 16 cycles.
- Reset release, no keys -> `o_col` 1110, 1101, 1011, 0111, 1110 each held 4 cycles; `o_data`=0, `o_valid`=0 throughout.
- Row1 pulled low while col2 is active, held 3 scans, then released; later key row2/col2 held 3 scans -> `o_data`=0x00000006 then 0x0000006A; `o_valid` rises once per key.
- Row1/col2 asserted for 1 scan only -> no commit. Rows 0 and 3 low together for 5 scans -> no commit. Key held 10 scans after commit -> exactly one commit.
- `cs`+`i_rd` after commit -> `o_valid` 0, `o_data` unchanged. `cs`+`i_wr` -> `o_data`=0. Either strobe in the commit cycle of key 0xF -> `o_valid`=1 and `o_data`[3:0]=0xF (after wr: 0x0000000F).
- Nine keys 1..9 committed -> `o_data`=0x23456789.
- `reset` asserted in DEBOUNCE after 1 matching scan, key still held afterward -> outputs return to reset values; commit requires 2 fresh scans after release of reset.
